// File: rtl/sdram_port_arbiter.sv
// Round-robin two-client front end for the SDRAM controller: issues one request
// pulse per transaction, waits for the completion edge (or a timeout) and acks the winner.
`timescale 1ns/1ps
module sdram_port_arbiter #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [23:0] p0_addr,
    input  logic [23:0] p1_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic        p0_err,
    output logic        p1_err,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic [23:0] address,
    output logic [31:0] data_in,
    output logic        req_read,
    output logic        req_write,
    input  logic [31:0] data_out,
    input  logic        data_valid,
    input  logic        write_complete
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t               state_r, state_s;
    logic                 last_grant_r, grant_r, op_r;
    logic                 dv_prev_r, wc_prev_r;
    logic [TIMEOUT_W-1:0] cnt_r;
    logic                 grant_valid_s, grant_port_s, done_s, timeout_s;
    logic                 dv_rise_s, wc_rise_s;

    assign dv_rise_s = data_valid & ~dv_prev_r;
    assign wc_rise_s = write_complete & ~wc_prev_r;

    // Next-state logic: grant selection, completion and timeout detection.
    always_comb begin
        state_s       = state_r;
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
        done_s        = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (p0_req && p1_req) begin
                    grant_valid_s = 1'b1;
                    grant_port_s  = ~last_grant_r;
                end else if (p0_req) begin
                    grant_valid_s = 1'b1;
                    grant_port_s  = 1'b0;
                end else if (p1_req) begin
                    grant_valid_s = 1'b1;
                    grant_port_s  = 1'b1;
                end else begin
                    grant_valid_s = 1'b0;
                end
                if (grant_valid_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                // Only the edge matching the latched operation completes it.
                if (op_r ? wc_rise_s : dv_rise_s) begin
                    done_s  = 1'b1;
                    state_s = RESP;
                end else if (cnt_r == {TIMEOUT_W{1'b1}}) begin
                    timeout_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: latched request, strobes, timeout counter, edge history and read data.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            op_r         <= 1'b0;
            dv_prev_r    <= 1'b0;
            wc_prev_r    <= 1'b0;
            cnt_r        <= CNT_ZERO;
            address      <= 24'h000000;
            data_in      <= 32'h00000000;
            req_read     <= 1'b0;
            req_write    <= 1'b0;
            p0_ack       <= 1'b0;
            p1_ack       <= 1'b0;
            p0_err       <= 1'b0;
            p1_err       <= 1'b0;
            p0_rdata     <= 32'h00000000;
            p1_rdata     <= 32'h00000000;
        end else begin
            dv_prev_r <= data_valid;
            wc_prev_r <= write_complete;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            // The pulse is registered on the grant edge so it is high during ISSUE.
            if (grant_valid_s) begin
                grant_r      <= grant_port_s;
                last_grant_r <= grant_port_s;
                address      <= grant_port_s ? p1_addr : p0_addr;
                data_in      <= grant_port_s ? p1_wdata : p0_wdata;
                op_r         <= grant_port_s ? p1_we : p0_we;
                req_read     <= ~(grant_port_s ? p1_we : p0_we);
                req_write    <= grant_port_s ? p1_we : p0_we;
            end
            if (state_r == ISSUE) begin
                cnt_r <= CNT_ZERO;
            end else if ((state_r == WAIT) && !done_s && !timeout_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (done_s || timeout_s) begin
                if (grant_r) begin
                    p1_ack <= 1'b1;
                    p1_err <= timeout_s;
                end else begin
                    p0_ack <= 1'b1;
                    p0_err <= timeout_s;
                end
            end
            if (done_s && !op_r) begin
                if (grant_r) begin
                    p1_rdata <= data_out;
                end else begin
                    p0_rdata <= data_out;
                end
            end
        end
    end
endmodule
